accumulate_driver: RTL and testbench

Host-side sequencer for the synthesized `main` accumulate kernel and its 1000 × 64-bit array `arr_a`. Per job it takes a command, streams N signed words into the array through the `controlArr*` back door, starts the kernel, waits for completion, then streams the N in-place prefix sums back out. It sits directly upstream and downstream of `main`. It is the only agent that drives `main`'s control and array ports.

---
 rtl/accumulate_driver_pkg.sv | 10 +
 rtl/accumulate_driver_if.sv | 27 ++
 rtl/accumulate_driver.sv | 120 ++++++++++++
 tb/tb_accumulate_driver.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/accumulate_driver_pkg.sv
// Shared types and sizing for the accumulate kernel host-side sequencer.
package accumulate_pkg;
   localparam int N  = 1000;
   localparam int AW = 10;
   localparam int DW = 64;

   typedef logic signed [DW-1:0] word_t;

   typedef enum logic [2:0] {IDLE, LOAD, START, RUN, DRAIN} state_t;
endpackage

// File: rtl/accumulate_driver_if.sv
// Host-facing command, load and result streams of accumulate_driver.
interface accumulate_driver_if;
   import accumulate_pkg::*;

   logic  cmd_valid;
   logic  cmd_ready;
   word_t cmd_acc_init;
   logic  in_valid;
   logic  in_ready;
   word_t in_data;
   logic  out_valid;
   logic  out_ready;
   word_t out_data;
   logic  out_last;
   logic  job_done;
   logic  job_result;

   modport master (
      output cmd_valid, cmd_acc_init, in_valid, in_data, out_ready,
      input  cmd_ready, in_ready, out_valid, out_data, out_last, job_done, job_result
   );

   modport slave (
      input  cmd_valid, cmd_acc_init, in_valid, in_data, out_ready,
      output cmd_ready, in_ready, out_valid, out_data, out_last, job_done, job_result
   );
endinterface

// File: rtl/accumulate_driver.sv
// Sequences one accumulate job on `main`: load arr_a, pulse start, wait for
// completion, then stream the in-place prefix sums back out.
module accumulate_driver #(
   parameter int N  = accumulate_pkg::N,
   parameter int AW = accumulate_pkg::AW,
   parameter int DW = accumulate_pkg::DW
) (
   input  logic                 clk,
   input  logic                 rst_n,
   accumulate_driver_if.slave   host,
   output logic                 r_enable,
   output logic [AW-1:0]        init_i_t_a,
   output logic signed [DW-1:0] init_acc_t_a,
   output logic                 controlArr,
   output logic                 controlArrWEnable_a,
   output logic [AW-1:0]        controlArrAddr_a,
   output logic signed [DW-1:0] controlArrWData_a,
   input  logic signed [DW-1:0] controlArrRData_a,
   input  logic                 w_enable,
   input  logic                 result
);
   import accumulate_pkg::*;

   localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

   state_t               state_q, state_d;
   logic [AW-1:0]        idx_q, idx_d;
   logic signed [DW-1:0] acc_init_q;
   logic                 job_result_q;
   logic                 out_vld_p1;
   logic                 fire;
   logic                 last_beat;

   assign fire      = out_vld_p1 & host.out_ready;
   assign last_beat = (idx_q == LAST_IDX);

   assign host.out_valid  = out_vld_p1;
   assign host.out_data   = controlArrRData_a;
   assign host.out_last   = out_vld_p1 & last_beat;
   assign host.job_done   = fire & last_beat;
   assign host.job_result = job_result_q;
   assign init_i_t_a      = '0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         job_result_q <= 1'b0;
         out_vld_p1   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         if (state_q == RUN && w_enable)
            job_result_q <= result;
         // stage p1: read data for idx arrives one cycle after its address
         out_vld_p1 <= (state_q == DRAIN) && !(fire && last_beat);
      end
   end

   always_ff @(posedge clk) begin
      if (state_q == IDLE && host.cmd_valid)
         acc_init_q <= host.cmd_acc_init;
   end

   always_comb begin
      state_d             = state_q;
      idx_d               = idx_q;
      host.cmd_ready      = 1'b0;
      host.in_ready       = 1'b0;
      r_enable            = 1'b0;
      init_acc_t_a        = '0;
      controlArr          = 1'b0;
      controlArrWEnable_a = 1'b0;
      controlArrAddr_a    = '0;
      controlArrWData_a   = '0;
      case (state_q)
         IDLE: begin
            host.cmd_ready = 1'b1;
            if (host.cmd_valid) begin
               idx_d   = '0;
               state_d = LOAD;
            end
         end
         LOAD: begin
            controlArr          = 1'b1;
            host.in_ready       = 1'b1;
            controlArrWEnable_a = host.in_valid;
            controlArrAddr_a    = idx_q;
            controlArrWData_a   = host.in_data;
            if (host.in_valid) begin
               idx_d = idx_q + 1'b1;
               if (last_beat)
                  state_d = START;
            end
         end
         START: begin
            r_enable     = 1'b1;
            init_acc_t_a = acc_init_q;
            state_d      = RUN;
         end
         RUN: begin
            if (w_enable) begin
               idx_d   = '0;
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            // Look ahead on a fire so the next word lands without a bubble.
            controlArr       = 1'b1;
            controlArrAddr_a = fire ? idx_q + 1'b1 : idx_q;
            if (fire) begin
               idx_d = idx_q + 1'b1;
               if (last_beat)
                  state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end
endmodule

// File: tb/tb_accumulate_driver.sv
// Randomized bench for accumulate_driver with a behavioural stand-in for `main`.
module tb_accumulate_driver;
   import accumulate_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   accumulate_driver_if hif ();

   logic          r_enable;
   logic [AW-1:0] init_i_t_a;
   word_t         init_acc_t_a;
   logic          controlArr;
   logic          controlArrWEnable_a;
   logic [AW-1:0] controlArrAddr_a;
   word_t         controlArrWData_a;
   word_t         controlArrRData_a = '0;
   logic          w_enable = 1'b0;
   logic          result = 1'b0;

   accumulate_driver dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .host                (hif),
      .r_enable            (r_enable),
      .init_i_t_a          (init_i_t_a),
      .init_acc_t_a        (init_acc_t_a),
      .controlArr          (controlArr),
      .controlArrWEnable_a (controlArrWEnable_a),
      .controlArrAddr_a    (controlArrAddr_a),
      .controlArrWData_a   (controlArrWData_a),
      .controlArrRData_a   (controlArrRData_a),
      .w_enable            (w_enable),
      .result              (result)
   );

   // Stand-in for the `main` kernel: array with 1-cycle reads, variable run time.
   word_t arr [N];
   word_t k_acc;
   word_t k_sum;
   int    k_cnt    = 0;
   bit    k_busy   = 1'b0;
   int    n_starts = 0;

   always @(posedge clk) begin
      if (controlArr && controlArrWEnable_a)
         arr[controlArrAddr_a] <= controlArrWData_a;
      controlArrRData_a <= (int'(controlArrAddr_a) < N) ? arr[controlArrAddr_a] : '0;
      if (r_enable) begin
         w_enable <= 1'b0;
         k_busy   <= 1'b1;
         k_cnt    <= $urandom_range(3, 40);
         k_acc    <= init_acc_t_a;
         n_starts <= n_starts + 1;
      end else if (k_busy) begin
         if (k_cnt == 0) begin
            k_sum = k_acc;
            for (int i = 0; i < N; i++) begin
               k_sum = k_sum + arr[i];
               arr[i] <= k_sum;
            end
            w_enable <= 1'b1;
            result   <= 1'($urandom_range(0, 1));
            k_busy   <= 1'b0;
         end else begin
            k_cnt <= k_cnt - 1;
         end
      end
   end

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                  tag, $signed(obs), obs, $signed(exp), exp);
      end
   endtask

   word_t stim  [N];
   word_t expv  [N];
   word_t obs_v [N];

   task automatic run_job(input word_t init, input int mode, input int gap_pct,
                          input int rdy_pct, input bit abort_mid, input bit hold_cmd);
      word_t run;
      word_t held;
      bit    stalled;
      int    k, cyc, beats, first_cyc, starts0;

      for (int i = 0; i < N; i++) begin
         case (mode)
            0:       stim[i] = word_t'(i);
            1:       stim[i] = word_t'(1);
            2:       stim[i] = (i < 2) ? word_t'(64'h7FFF_FFFF_FFFF_FFFF) : word_t'(0);
            3:       stim[i] = {$urandom, $urandom};
            default: stim[i] = word_t'(2);
         endcase
      end
      run = init;
      for (int i = 0; i < N; i++) begin
         run     = run + stim[i];
         expv[i] = run;
      end
      starts0 = n_starts;

      cyc = 0;
      do begin
         @(negedge clk);
         hif.cmd_valid    = 1'b1;
         hif.cmd_acc_init = init;
         #1;
         cyc++;
      end while (!hif.cmd_ready && cyc < 50);
      check("cmd_accept", hif.cmd_ready, 1);

      k = 0;
      cyc = 0;
      while (k < N && cyc < 20 * N) begin
         @(negedge clk);
         if (abort_mid && k == 300) begin
            hif.in_valid = 1'b0;
            hif.cmd_valid = 1'b0;
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            #1;
            check("rst_cmd_ready", hif.cmd_ready, 1);
            check("rst_in_ready", hif.in_ready, 0);
            check("rst_controlArr", controlArr, 0);
            check("rst_r_enable", r_enable, 0);
            return;
         end
         hif.cmd_valid = hold_cmd;
         hif.in_valid  = ($urandom_range(0, 99) >= gap_pct);
         hif.in_data   = stim[k];
         #1;
         cyc++;
         if (cyc == 1) begin
            check("load_cmd_ready", hif.cmd_ready, 0);
            check("load_in_ready", hif.in_ready, 1);
         end
         if (hif.in_valid && hif.in_ready)
            k++;
      end
      check("load_done", k, N);

      beats     = 0;
      cyc       = 0;
      first_cyc = -1;
      stalled   = 1'b0;
      held      = '0;
      while (beats < N && cyc < 40 * N + 200) begin
         @(negedge clk);
         hif.in_valid  = 1'b1;
         hif.cmd_valid = hold_cmd;
         hif.out_ready = ($urandom_range(0, 99) < rdy_pct);
         #1;
         cyc++;
         if (cyc == 1) begin
            check("start_in_ready", hif.in_ready, 0);
            check("start_r_enable", r_enable, 1);
            check("start_init_acc", init_acc_t_a, init);
            check("start_init_i", init_i_t_a, 0);
         end
         if (hold_cmd)
            check("cmd_held_off", hif.cmd_ready, 0);
         if (!controlArr) begin
            check("ctl_zero_addr", {controlArrWEnable_a, controlArrAddr_a}, 0);
            check("ctl_zero_wdata", controlArrWData_a, 0);
         end
         if (hif.out_valid) begin
            if (first_cyc < 0)
               first_cyc = cyc;
            if (stalled)
               check("stall_hold", hif.out_data, held);
            check("out_data", hif.out_data, expv[beats]);
            check("out_last", hif.out_last, beats == N - 1);
            check("job_done", hif.job_done, hif.out_ready && beats == N - 1);
            if (hif.out_ready) begin
               obs_v[beats] = hif.out_data;
               beats++;
               stalled = 1'b0;
            end else begin
               stalled = 1'b1;
               held    = hif.out_data;
            end
         end else begin
            check("done_idle", hif.job_done, 0);
         end
      end
      check("drain_done", beats, N);
      if (rdy_pct == 100)
         check("drain_rate", cyc - first_cyc + 1, N);
      check("job_result", hif.job_result, result);
      check("start_pulses", n_starts - starts0, 1);

      @(negedge clk);
      hif.cmd_valid = 1'b0;
      hif.in_valid  = 1'b0;
      hif.out_ready = 1'b0;
      #1;
      check("idle_cmd_ready", hif.cmd_ready, 1);
      check("idle_out_valid", hif.out_valid, 0);
   endtask

   word_t init_r;

   initial begin
      hif.cmd_valid    = 1'b0;
      hif.cmd_acc_init = '0;
      hif.in_valid     = 1'b0;
      hif.in_data      = '0;
      hif.out_ready    = 1'b0;
      rst_n            = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("rst_cmd_ready", hif.cmd_ready, 1);
      check("rst_in_ready", hif.in_ready, 0);
      check("rst_out_valid", hif.out_valid, 0);
      check("rst_out_last", hif.out_last, 0);
      check("rst_job_done", hif.job_done, 0);
      check("rst_r_enable", r_enable, 0);
      check("rst_controlArr", controlArr, 0);
      check("rst_wenable", controlArrWEnable_a, 0);
      check("rst_job_result", hif.job_result, 0);
      rst_n = 1'b1;

      run_job(word_t'(0), 0, 0, 100, 1'b0, 1'b0);
      check("ramp_out0", obs_v[0], 0);
      check("ramp_out1", obs_v[1], 1);
      check("ramp_out999", obs_v[N-1], 499500);

      run_job(word_t'(-5), 1, 0, 100, 1'b0, 1'b0);
      check("ones_out0", obs_v[0], word_t'(-4));
      check("ones_out999", obs_v[N-1], 995);

      run_job(word_t'(0), 2, 0, 100, 1'b0, 1'b0);
      check("wrap_out1", obs_v[1], word_t'(-2));
      check("wrap_out999", obs_v[N-1], word_t'(-2));

      run_job({$urandom, $urandom}, 3, 30, 50, 1'b0, 1'b0);

      run_job({$urandom, $urandom}, 3, 0, 100, 1'b1, 1'b0);
      init_r = word_t'($signed($urandom_range(0, 100000))) - word_t'(50000);
      run_job(init_r, 4, 10, 80, 1'b0, 1'b0);
      check("post_rst_out999", obs_v[N-1], init_r + word_t'(2000));

      run_job({$urandom, $urandom}, 3, 0, 100, 1'b0, 1'b1);
      run_job({$urandom, $urandom}, 3, 20, 70, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
